fft_8_frame_loader: RTL and testbench

Upstream feeder for the 8-point FFT datapath. Accepts a serial stream of complex samples over a valid/ready handshake and assembles them into 8-sample frames in a ping-pong (two-bank) buffer. Each completed frame is presented in parallel, natural order, on the sixteen FFT input buses with its own valid/ready handshake. Sustains one sample per clock while the consumer keeps up.

---
 rtl/fft_8_frame_loader.sv | 141 ++++++++++++++
 tb/tb_fft_8_frame_loader.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_8_frame_loader.sv
// Frame loader for the 8-point FFT: assembles a serial stream of complex
// samples into 8-sample frames in a two-bank buffer. Each finished frame is
// presented in parallel, in arrival order, with its own valid/ready handshake.
module fft_8_frame_loader #(
    parameter int N = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic              s_sof,
    input  logic [2**N-1:0]   s_re,
    input  logic [2**N-1:0]   s_im,
    output logic              frame_valid,
    input  logic              frame_ready,
    output logic [2**N-1:0]   out_0_r,
    output logic [2**N-1:0]   out_0_i,
    output logic [2**N-1:0]   out_1_r,
    output logic [2**N-1:0]   out_1_i,
    output logic [2**N-1:0]   out_2_r,
    output logic [2**N-1:0]   out_2_i,
    output logic [2**N-1:0]   out_3_r,
    output logic [2**N-1:0]   out_3_i,
    output logic [2**N-1:0]   out_4_r,
    output logic [2**N-1:0]   out_4_i,
    output logic [2**N-1:0]   out_5_r,
    output logic [2**N-1:0]   out_5_i,
    output logic [2**N-1:0]   out_6_r,
    output logic [2**N-1:0]   out_6_i,
    output logic [2**N-1:0]   out_7_r,
    output logic [2**N-1:0]   out_7_i,
    output logic              resync_err
);

    localparam int W = 2**N;

    // Storage is kept in flops: all eight entries of the read bank are needed
    // in parallel every cycle, so a block RAM cannot serve it.
    logic [W-1:0] r_re [2][8];
    logic [W-1:0] r_im [2][8];

    logic [1:0]   r_full;
    logic         r_wr_bank;
    logic         r_rd_bank;
    logic [2:0]   r_wr_idx;
    logic         r_resync_err;

    logic         w_accept;
    logic         w_release;
    logic         w_complete;
    logic [2:0]   w_idx;
    logic [1:0]   w_full_next;
    logic [W-1:0] w_out_r [8];
    logic [W-1:0] w_out_i [8];

    // Ready depends on state only, so the consumer's ready never reaches s_ready
    // combinationally. The write bank is only full when both banks are.
    assign s_ready     = ~r_full[r_wr_bank];
    assign w_accept    = s_valid & s_ready;
    assign frame_valid = r_full[r_rd_bank];
    assign w_release   = frame_valid & frame_ready;
    assign resync_err  = r_resync_err;

    // A start-of-frame sample always lands in entry 0, discarding any partial frame.
    assign w_idx      = s_sof ? 3'd0 : r_wr_idx;
    assign w_complete = w_accept & (w_idx == 3'd7);

    // Completion and release always refer to different banks (the write bank
    // is never full while accepting), so both updates can apply together.
    always_comb begin
        w_full_next = r_full;
        if (w_release) begin
            w_full_next[r_rd_bank] = 1'b0;
        end
        if (w_complete) begin
            w_full_next[r_wr_bank] = 1'b1;
        end
    end

    // Control state: bank occupancy, bank pointers, write index, resync pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_full       <= 2'b00;
            r_wr_bank    <= 1'b0;
            r_rd_bank    <= 1'b0;
            r_wr_idx     <= 3'd0;
            r_resync_err <= 1'b0;
        end else begin
            r_full       <= w_full_next;
            r_resync_err <= w_accept & s_sof & (r_wr_idx != 3'd0);
            if (w_accept) begin
                r_wr_idx <= w_complete ? 3'd0 : w_idx + 3'd1;
            end
            if (w_complete) begin
                r_wr_bank <= ~r_wr_bank;
            end
            if (w_release) begin
                r_rd_bank <= ~r_rd_bank;
            end
        end
    end

    // Sample storage: write the accepted sample into the current bank/entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int b = 0; b < 2; b++) begin
                for (int k = 0; k < 8; k++) begin
                    r_re[b][k] <= '0;
                    r_im[b][k] <= '0;
                end
            end
        end else if (w_accept) begin
            r_re[r_wr_bank][w_idx] <= s_re;
            r_im[r_wr_bank][w_idx] <= s_im;
        end
    end

    // Parallel frame view of the read bank.
    for (genvar gi = 0; gi < 8; gi++) begin : g_out
        assign w_out_r[gi] = r_re[r_rd_bank][gi];
        assign w_out_i[gi] = r_im[r_rd_bank][gi];
    end

    assign out_0_r = w_out_r[0];
    assign out_0_i = w_out_i[0];
    assign out_1_r = w_out_r[1];
    assign out_1_i = w_out_i[1];
    assign out_2_r = w_out_r[2];
    assign out_2_i = w_out_i[2];
    assign out_3_r = w_out_r[3];
    assign out_3_i = w_out_i[3];
    assign out_4_r = w_out_r[4];
    assign out_4_i = w_out_i[4];
    assign out_5_r = w_out_r[5];
    assign out_5_i = w_out_i[5];
    assign out_6_r = w_out_r[6];
    assign out_6_i = w_out_i[6];
    assign out_7_r = w_out_r[7];
    assign out_7_i = w_out_i[7];

endmodule

// File: tb/tb_fft_8_frame_loader.sv
// Bench for fft_8_frame_loader: a directed vector table, hand-written
// backpressure / throughput / reset sequences, and randomized traffic, all
// checked against a queue-based frame model.
module tb_fft_8_frame_loader;

    localparam int N = 4;
    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         s_valid = 1'b0;
    logic         s_sof = 1'b0;
    logic         frame_ready = 1'b0;
    logic [W-1:0] s_re = '0;
    logic [W-1:0] s_im = '0;
    logic         s_ready, frame_valid, resync_err;
    logic [W-1:0] out_0_r, out_1_r, out_2_r, out_3_r, out_4_r, out_5_r, out_6_r, out_7_r;
    logic [W-1:0] out_0_i, out_1_i, out_2_i, out_3_i, out_4_i, out_5_i, out_6_i, out_7_i;
    logic [127:0] dut_re, dut_im;

    int checks = 0;
    int errors = 0;

    fft_8_frame_loader #(.N(N)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_valid(s_valid), .s_ready(s_ready), .s_sof(s_sof),
        .s_re(s_re), .s_im(s_im),
        .frame_valid(frame_valid), .frame_ready(frame_ready),
        .out_0_r(out_0_r), .out_0_i(out_0_i), .out_1_r(out_1_r), .out_1_i(out_1_i),
        .out_2_r(out_2_r), .out_2_i(out_2_i), .out_3_r(out_3_r), .out_3_i(out_3_i),
        .out_4_r(out_4_r), .out_4_i(out_4_i), .out_5_r(out_5_r), .out_5_i(out_5_i),
        .out_6_r(out_6_r), .out_6_i(out_6_i), .out_7_r(out_7_r), .out_7_i(out_7_i),
        .resync_err(resync_err)
    );

    always #5 clk = ~clk;

    assign dut_re = {out_7_r, out_6_r, out_5_r, out_4_r, out_3_r, out_2_r, out_1_r, out_0_r};
    assign dut_im = {out_7_i, out_6_i, out_5_i, out_4_i, out_3_i, out_2_i, out_1_i, out_0_i};

    // Reference model: completed frames in order, plus the partial frame.
    logic [127:0] q_re [$];
    logic [127:0] q_im [$];
    logic [W-1:0] p_re [$];
    logic [W-1:0] p_im [$];
    logic         m_rerr = 1'b0;
    int           frames_out = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%b required=%b", name, act, exp);
        end
    endtask

    task automatic model_reset();
        q_re.delete();
        q_im.delete();
        p_re.delete();
        p_im.delete();
        m_rerr = 1'b0;
    endtask

    // Outputs reflect state only, so they are checked before the edge.
    task automatic check_model();
        chk1("s_ready", s_ready, q_re.size() < 2);
        chk1("frame_valid", frame_valid, q_re.size() > 0);
        chk1("resync_err", resync_err, m_rerr);
        if (q_re.size() > 0) begin
            chk("frame_re", dut_re, q_re[0]);
            chk("frame_im", dut_im, q_im[0]);
        end
    endtask

    task automatic model_step(input logic v, input logic sof, input logic [W-1:0] re,
                              input logic [W-1:0] im, input logic fr);
        bit           acc;
        bit           rel;
        bit           rerr_next;
        logic [127:0] fre;
        logic [127:0] fim;
        acc       = v && (q_re.size() < 2);
        rel       = fr && (q_re.size() > 0);
        rerr_next = acc && sof && (p_re.size() != 0);
        if (rel) begin
            $display("frame %0d released: s0 re=%h im=%h s7 re=%h im=%h",
                     frames_out, q_re[0][15:0], q_im[0][15:0], q_re[0][127:112], q_im[0][127:112]);
            frames_out++;
            void'(q_re.pop_front());
            void'(q_im.pop_front());
        end
        if (acc) begin
            if (sof) begin
                p_re.delete();
                p_im.delete();
            end
            p_re.push_back(re);
            p_im.push_back(im);
            if (p_re.size() == 8) begin
                for (int k = 0; k < 8; k++) begin
                    fre[16*k +: 16] = p_re[k];
                    fim[16*k +: 16] = p_im[k];
                end
                q_re.push_back(fre);
                q_im.push_back(fim);
                p_re.delete();
                p_im.delete();
            end
        end
        m_rerr = rerr_next;
    endtask

    // One clock: drive at the falling edge, check, step the model at the rising edge.
    task automatic cycle(input logic v, input logic sof, input logic [W-1:0] re,
                         input logic [W-1:0] im, input logic fr);
        s_valid     = v;
        s_sof       = sof;
        s_re        = re;
        s_im        = im;
        frame_ready = fr;
        check_model();
        @(posedge clk);
        model_step(v, sof, re, im, fr);
        @(negedge clk);
    endtask

    typedef struct {
        logic         v;
        logic         sof;
        logic [W-1:0] re;
        logic [W-1:0] im;
        logic         fr;
        logic         e_srdy;
        logic         e_fv;
        logic         e_rerr;
        logic         chk_d;
        logic [W-1:0] e_o0r;
        logic [W-1:0] e_o7i;
    } vec_t;

    vec_t tbl [23];

    initial begin
        int base;

        // Directed frame: re=k+1, im=-(k+1), then two idle cycles.
        for (int k = 0; k < 10; k++) begin
            tbl[k] = '{v: (k < 8), sof: 1'b0, re: (k < 8) ? 16'(k + 1) : 16'h0,
                       im: (k < 8) ? 16'(-(k + 1)) : 16'h0, fr: 1'b1,
                       e_srdy: 1'b1, e_fv: (k == 8), e_rerr: 1'b0,
                       chk_d: (k == 8), e_o0r: 16'h0001, e_o7i: 16'hFFF8};
        end
        // Resync: 3 samples, an s_sof sample 0x55, 7 more, then two idle cycles.
        for (int j = 0; j < 13; j++) begin
            tbl[10 + j] = '{v: (j < 11), sof: (j == 3),
                            re: (j < 3) ? 16'(16'hA0 + j) : (j == 3) ? 16'h0055 : 16'(16'h56 + j - 4),
                            im: (j < 3) ? 16'(j) : (j == 3) ? 16'h0155 : 16'h0000,
                            fr: 1'b1, e_srdy: 1'b1, e_fv: (j == 11), e_rerr: (j == 4),
                            chk_d: (j == 11), e_o0r: 16'h0055, e_o7i: 16'h0000};
        end

        // Reset state.
        @(negedge clk);
        @(negedge clk);
        chk1("rst_s_ready", s_ready, 1'b1);
        chk1("rst_frame_valid", frame_valid, 1'b0);
        chk1("rst_resync_err", resync_err, 1'b0);
        chk("rst_out_re", dut_re, 128'h0);
        chk("rst_out_im", dut_im, 128'h0);
        rst_n = 1'b1;
        model_reset();

        // Table-driven vectors.
        for (int i = 0; i < 23; i++) begin
            s_valid     = tbl[i].v;
            s_sof       = tbl[i].sof;
            s_re        = tbl[i].re;
            s_im        = tbl[i].im;
            frame_ready = tbl[i].fr;
            chk1($sformatf("tbl%0d_s_ready", i), s_ready, tbl[i].e_srdy);
            chk1($sformatf("tbl%0d_frame_valid", i), frame_valid, tbl[i].e_fv);
            chk1($sformatf("tbl%0d_resync_err", i), resync_err, tbl[i].e_rerr);
            if (tbl[i].chk_d) begin
                chk($sformatf("tbl%0d_out_0_r", i), 128'(out_0_r), 128'(tbl[i].e_o0r));
                chk($sformatf("tbl%0d_out_7_i", i), 128'(out_7_i), 128'(tbl[i].e_o7i));
            end
            check_model();
            @(posedge clk);
            model_step(tbl[i].v, tbl[i].sof, tbl[i].re, tbl[i].im, tbl[i].fr);
            @(negedge clk);
        end

        // Backpressure: 20 samples with frame_ready low; both banks fill.
        for (int i = 0; i < 20; i++) begin
            chk1($sformatf("bp%0d_s_ready", i), s_ready, i < 16);
            cycle(1'b1, 1'b0, 16'(100 + i), 16'(200 + i), 1'b0);
        end
        cycle(1'b0, 1'b0, 16'h0, 16'h0, 1'b1);
        chk1("bp_ready_after_release", s_ready, 1'b1);
        chk("bp_frame1_s0", 128'(out_0_r), 128'(16'd108));
        chk("bp_frame1_s7", 128'(out_7_i), 128'(16'd215));
        cycle(1'b0, 1'b0, 16'h0, 16'h0, 1'b1);
        cycle(1'b0, 1'b0, 16'h0, 16'h0, 1'b1);

        // Throughput: 64 back-to-back samples, consumer always ready.
        base = frames_out;
        for (int i = 0; i < 64; i++) begin
            chk1($sformatf("b2b%0d_s_ready", i), s_ready, 1'b1);
            cycle(1'b1, 1'b0, 16'(i), 16'(16'h1000 + i), 1'b1);
        end
        cycle(1'b0, 1'b0, 16'h0, 16'h0, 1'b1);
        cycle(1'b0, 1'b0, 16'h0, 16'h0, 1'b1);
        chk("b2b_frames", 128'(frames_out - base), 128'(8));

        // Reset with one full frame held and 5 samples buffered; async assert mid-cycle.
        for (int i = 0; i < 13; i++) begin
            cycle(1'b1, 1'b0, 16'(16'h300 + i), 16'(16'h400 + i), 1'b0);
        end
        s_valid = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        chk1("arst_frame_valid", frame_valid, 1'b0);
        chk1("arst_s_ready", s_ready, 1'b1);
        chk("arst_out_re", dut_re, 128'h0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            cycle(1'b1, 1'b0, 16'(16'h500 + i), 16'(16'h600 + i), 1'b0);
        end
        chk1("post_rst_frame_valid", frame_valid, 1'b1);
        chk("post_rst_s0", 128'(out_0_r), 128'(16'h500));
        cycle(1'b0, 1'b0, 16'h0, 16'h0, 1'b1);

        // Randomized traffic with bursts of consumer stall.
        for (int i = 0; i < 600; i++) begin
            logic v, sof, fr;
            v   = ($urandom_range(0, 3) != 0);
            sof = ($urandom_range(0, 19) == 0);
            fr  = (((i / 40) % 3) == 1) ? 1'b0 : ($urandom_range(0, 3) != 0);
            cycle(v, sof, 16'($urandom), 16'($urandom), fr);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
